serv_immdec_par: RTL and testbench
==================================

# serv_immdec_par

Parametrised bit-serial immediate decoder for the SERV core. It captures the fetched instruction, assembles the 32-bit immediate for a selected format (I/S/B/U/J/CSR), and shifts it out LSB-first, W bits per enabled cycle, to the serial ALU and CTRL datapath. It also latches the rd/rs1/rs2 register-file addresses. It replaces the fixed 1-bit decoder with a width-generic version that has an explicit beat counter and last-beat signalling.

## Interface

Parameters:
- `W`, default 1: bits per shift beat; legal values 1, 2, 4. Beat count N = 32/W.

Ports (name, direction, width, meaning):
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset. Asynchronous, active-high.
- `i_wb_en`, in, 1: instruction-bus acknowledge. Captures `i_wb_rdt` and `i_imm_type`.
- `i_wb_rdt`, in, [31:2]: instruction word.
- `i_imm_type`, in, 3: immediate format.
  - 0 = I, 1 = S, 2 = B, 3 = U, 4 = J.
  - 5 = CSR: the 5-bit rs1 field, zero-extended.
  - 6 and 7 = zero immediate.
- `i_cnt_en`, in, 1: advance one beat.
- `o_imm`, out, [W-1:0]: current immediate beat, LSB-first.
- `o_last`, out, 1: the current beat is beat N-1.
- `o_busy`, out, 1: beats remain (beat counter < N).
- `o_rf_rd_addr`, out, 5: `rdt[11:7]`.
- `o_rf_rs1_addr`, out, 5: `rdt[19:15]`.
- `o_rf_rs2_addr`, out, 5: `rdt[24:20]`.

## Operation

- **Load.** On a clock edge with `i_wb_en`=1:
  - A 32-bit shift register `sreg` loads the fully assembled immediate (RISC-V base encodings):
    - I: sext `rdt[31:20]`.
    - S: sext `{rdt[31:25], rdt[11:7]}`.
    - B: sext `{rdt[31], rdt[7], rdt[30:25], rdt[11:8], 0}`.
    - U: `{rdt[31:12], 12'b0}`.
    - J: sext `{rdt[31], rdt[19:12], rdt[20], rdt[30:21], 0}`.
    - CSR: `{27'b0, rdt[19:15]}`.
  - The fill bit `fill` loads as follows: `rdt[31]` for types I/S/B/J/U; 0 for CSR and for types 6/7.
  - The beat counter `beat` clears to 0.
  - The three address outputs load.
- **Shift.** On a clock edge with `i_cnt_en`=1 and `i_wb_en`=0:
  - `sreg` shifts right by W, and the top W bits fill with `fill`.
  - `beat` increments and saturates at N.
- **Output.** `o_imm` = `sreg[W-1:0]`, combinational from the register.
- **Overrun.** Enables after `beat`=N continue shifting, so `o_imm` = W copies of `fill`. This is the sign extension for 64-bit-style overrun. `beat` stays at N.
- **Simultaneous events.** If `i_wb_en` and `i_cnt_en` are both 1 in the same cycle, the load wins and no shift occurs.
- **Status.**
  - `o_last` = (`beat` == N-1).
  - `o_busy` = (`beat` < N).
- **Addresses.** `o_rf_*` hold their value until the next load and are unaffected by `i_cnt_en`.

## Timing

- **Reset.** Asserting `i_rst` immediately (asynchronously) forces the following, including mid-shift:
  - `sreg`=0, `fill`=0, `beat`=N.
  - Resulting outputs: `o_imm`=0, `o_busy`=0, `o_last`=0, all `o_rf_*`=0.
- **Reset release.** After release, nothing happens until the first `i_wb_en`. `i_cnt_en` before that shifts zeros.
- **Load latency.** 1 cycle. Beat 0 is valid on `o_imm` in the cycle after the `i_wb_en` edge, and `o_busy`=1 from then on.
- **Beat timing.**
  - Beat k is visible after k enabled edges since the load.
  - `o_last` is high while beat N-1 is presented.
  - `o_busy` falls after the N-th enable.
- **Gaps.** `i_cnt_en` may have gaps; the output holds during them.
- **Back-to-back.** A new `i_wb_en` during shifting aborts the current immediate. The new one is presented from the next cycle.

## Test plan

- **I-type sign, W=4.** Load `0x80000013` (addi imm=-2048), type 0, then 8 enables. Required beats: 0x0, 0x0, 0x8, 0xF, 0xF, 0xF, 0xF, 0xF. `o_last` is high on beat 7; `o_busy`=0 afterwards.
- **U-type, W=4.** Load `0x123450B7` (lui x1, 0x12345), type 3. Required:
  - Beats: 0, 0, 0, 5, 4, 3, 2, 1.
  - `o_rf_rd_addr`=1.
  - One overrun enable gives `o_imm`=0.
- **B-type, W=2.** Load `0x00000463` (beq x0,x0,+8), type 2. Required: beat0=0, beat1=2, beats 2–15=0, and `o_last` on beat 15.
- **CSR zero-extend, W=1.** Load `0x800FD073` (rs1 field=31, bit31=1), type 5. Required:
  - First 5 beats are 1, then 27 zeros.
  - Overrun beats are 0.
  - `o_rf_rs1_addr`=31.
- **Collision and abort, W=1.** Load an I-type with imm=-1, then 3 enables. On the next edge, assert `i_wb_en` together with `i_cnt_en` for U `0x000010B7`. Required:
  - Beats 0–2 are 1.
  - After the collision, `beat` restarts at 0 with `o_imm`=0.
  - Beat 12 is 1.
- **Async reset mid-shift, W=2.** After 5 enables, pulse `i_rst` between clock edges. Required: `o_imm`=0, `o_busy`=0, `o_rf_*`=0 immediately, without waiting for a clock edge. The next load then operates normally.

Source files
------------

// File: rtl/serv_immdec_par_if.sv
// Instruction-capture and immediate-beat signals between the SERV fetch/control
// logic (master) and the bit-serial immediate decoder (slave).
interface serv_immdec_par_if #(
    parameter int W = 1
);
    logic          i_wb_en;
    logic [31:2]   i_wb_rdt;
    logic [2:0]    i_imm_type;
    logic          i_cnt_en;
    logic [W-1:0]  o_imm;
    logic          o_last;
    logic          o_busy;
    logic [4:0]    o_rf_rd_addr;
    logic [4:0]    o_rf_rs1_addr;
    logic [4:0]    o_rf_rs2_addr;

    modport master (
        output i_wb_en, i_wb_rdt, i_imm_type, i_cnt_en,
        input  o_imm, o_last, o_busy, o_rf_rd_addr, o_rf_rs1_addr, o_rf_rs2_addr
    );

    modport slave (
        input  i_wb_en, i_wb_rdt, i_imm_type, i_cnt_en,
        output o_imm, o_last, o_busy, o_rf_rd_addr, o_rf_rs1_addr, o_rf_rs2_addr
    );
endinterface

// File: rtl/serv_immdec_par.sv
// Width-generic serial immediate decoder: captures an instruction, builds its
// 32-bit immediate and shifts it out W bits per enabled beat, LSB first.
module serv_immdec_par #(
    parameter int W = 1
) (
    input logic              i_clk,
    input logic              i_rst,
    serv_immdec_par_if.slave bus
);
    localparam int         N         = 32 / W;
    localparam logic [5:0] BeatCount = 6'(N);
    localparam logic [5:0] LastBeat  = 6'(N - 1);

    logic [31:2] rdt;
    logic [31:0] immAsm;
    logic        fillAsm;

    logic [31:0] shiftReg_q, shiftReg_d;
    logic        fill_q, fill_d;
    logic [5:0]  beat_q, beat_d;
    logic [4:0]  rdAddr_q, rdAddr_d;
    logic [4:0]  rs1Addr_q, rs1Addr_d;
    logic [4:0]  rs2Addr_q, rs2Addr_d;

    logic unusedOpcode;

    assign rdt          = bus.i_wb_rdt;
    assign unusedOpcode = ^rdt[6:2];

    // Immediate assembly; types 6/7 and CSR never sign-extend.
    always_comb begin
        immAsm  = '0;
        fillAsm = 1'b0;
        case (bus.i_imm_type)
            3'd0: begin
                immAsm  = {{20{rdt[31]}}, rdt[31:20]};
                fillAsm = rdt[31];
            end
            3'd1: begin
                immAsm  = {{20{rdt[31]}}, rdt[31:25], rdt[11:7]};
                fillAsm = rdt[31];
            end
            3'd2: begin
                immAsm  = {{19{rdt[31]}}, rdt[31], rdt[7], rdt[30:25], rdt[11:8], 1'b0};
                fillAsm = rdt[31];
            end
            3'd3: begin
                immAsm  = {rdt[31:12], 12'b0};
                fillAsm = rdt[31];
            end
            3'd4: begin
                immAsm  = {{11{rdt[31]}}, rdt[31], rdt[19:12], rdt[20], rdt[30:21], 1'b0};
                fillAsm = rdt[31];
            end
            3'd5: begin
                immAsm  = {27'b0, rdt[19:15]};
                fillAsm = 1'b0;
            end
            default: begin
                immAsm  = '0;
                fillAsm = 1'b0;
            end
        endcase
    end

    // A load always wins over a shift in the same cycle.
    always_comb begin
        shiftReg_d = shiftReg_q;
        fill_d     = fill_q;
        beat_d     = beat_q;
        rdAddr_d   = rdAddr_q;
        rs1Addr_d  = rs1Addr_q;
        rs2Addr_d  = rs2Addr_q;
        if (bus.i_wb_en) begin
            shiftReg_d = immAsm;
            fill_d     = fillAsm;
            beat_d     = 6'd0;
            rdAddr_d   = rdt[11:7];
            rs1Addr_d  = rdt[19:15];
            rs2Addr_d  = rdt[24:20];
        end else if (bus.i_cnt_en) begin
            shiftReg_d = {{W{fill_q}}, shiftReg_q[31:W]};
            beat_d     = (beat_q == BeatCount) ? beat_q : beat_q + 6'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shiftReg_q <= '0;
            fill_q     <= 1'b0;
            beat_q     <= BeatCount;
            rdAddr_q   <= '0;
            rs1Addr_q  <= '0;
            rs2Addr_q  <= '0;
        end else begin
            shiftReg_q <= shiftReg_d;
            fill_q     <= fill_d;
            beat_q     <= beat_d;
            rdAddr_q   <= rdAddr_d;
            rs1Addr_q  <= rs1Addr_d;
            rs2Addr_q  <= rs2Addr_d;
        end
    end

    assign bus.o_imm         = shiftReg_q[W-1:0];
    assign bus.o_last        = (beat_q == LastBeat);
    assign bus.o_busy        = (beat_q < BeatCount);
    assign bus.o_rf_rd_addr  = rdAddr_q;
    assign bus.o_rf_rs1_addr = rs1Addr_q;
    assign bus.o_rf_rs2_addr = rs2Addr_q;
endmodule

// File: tb/tb_serv_immdec_par.sv
// Drives W=1, W=2 and W=4 decoders with identical stimulus and checks them
// against an arithmetic model of the immediate formats and beat sequencing.
module tb_serv_immdec_par;
    localparam int BIG = 1000;

    logic        clk;
    logic        rst;
    logic        wbEn;
    logic [31:2] wbRdt;
    logic [2:0]  immType;
    logic        cntEn;

    int checks;
    int failures;

    logic [31:0] mImm;
    logic        mFill;
    int          mK;
    logic [4:0]  mRd, mRs1, mRs2;

    logic [3:0] gImm  [3];
    logic       gLast [3];
    logic       gBusy [3];
    logic [4:0] gRd   [3];
    logic [4:0] gRs1  [3];
    logic [4:0] gRs2  [3];

    serv_immdec_par_if #(.W(1)) bus1 ();
    serv_immdec_par_if #(.W(2)) bus2 ();
    serv_immdec_par_if #(.W(4)) bus4 ();

    assign bus1.i_wb_en = wbEn;  assign bus1.i_wb_rdt = wbRdt;
    assign bus1.i_imm_type = immType;  assign bus1.i_cnt_en = cntEn;
    assign bus2.i_wb_en = wbEn;  assign bus2.i_wb_rdt = wbRdt;
    assign bus2.i_imm_type = immType;  assign bus2.i_cnt_en = cntEn;
    assign bus4.i_wb_en = wbEn;  assign bus4.i_wb_rdt = wbRdt;
    assign bus4.i_imm_type = immType;  assign bus4.i_cnt_en = cntEn;

    serv_immdec_par #(.W(1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
    serv_immdec_par #(.W(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));
    serv_immdec_par #(.W(4)) dut4 (.i_clk(clk), .i_rst(rst), .bus(bus4));

    assign gImm[0] = {3'b0, bus1.o_imm};
    assign gImm[1] = {2'b0, bus2.o_imm};
    assign gImm[2] = bus4.o_imm;
    assign gLast[0] = bus1.o_last;  assign gLast[1] = bus2.o_last;  assign gLast[2] = bus4.o_last;
    assign gBusy[0] = bus1.o_busy;  assign gBusy[1] = bus2.o_busy;  assign gBusy[2] = bus4.o_busy;
    assign gRd[0]  = bus1.o_rf_rd_addr;   assign gRd[1]  = bus2.o_rf_rd_addr;   assign gRd[2]  = bus4.o_rf_rd_addr;
    assign gRs1[0] = bus1.o_rf_rs1_addr;  assign gRs1[1] = bus2.o_rf_rs1_addr;  assign gRs1[2] = bus4.o_rf_rs1_addr;
    assign gRs2[0] = bus1.o_rf_rs2_addr;  assign gRs2[1] = bus2.o_rf_rs2_addr;  assign gRs2[2] = bus4.o_rf_rs2_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  immType;
        logic [31:0] expImm;
        logic        expFill;
        logic [4:0]  expRd;
        logic [4:0]  expRs1;
        logic [4:0]  expRs2;
    } vector_t;

    function automatic int fld(logic [31:0] ins, int lo, int width);
        return int'((ins >> lo) & ((32'd1 << width) - 32'd1));
    endfunction

    // Immediate value computed as a signed sum of instruction fields.
    function automatic logic [31:0] refImm(logic [31:0] ins, logic [2:0] t);
        int sgn = ins[31] ? -1 : 0;
        int v;
        case (t)
            3'd0: v = sgn * 2048 + fld(ins, 20, 11);
            3'd1: v = sgn * 2048 + fld(ins, 25, 6) * 32 + fld(ins, 7, 5);
            3'd2: v = sgn * 4096 + fld(ins, 7, 1) * 2048 + fld(ins, 25, 6) * 32 + fld(ins, 8, 4) * 2;
            3'd3: v = int'(ins & 32'hFFFFF000);
            3'd4: v = sgn * 1048576 + fld(ins, 12, 8) * 4096 + fld(ins, 20, 1) * 2048 + fld(ins, 21, 10) * 2;
            3'd5: v = fld(ins, 15, 5);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    task automatic checkEq(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic checkOutput(string name);
        for (int d = 0; d < 3; d++) begin
            int          w   = 1 << d;
            int          n   = 32 >> d;
            int          kc  = (mK < n) ? mK : n;
            logic [63:0] ext = {{32{mFill}}, mImm};
            logic [3:0]  eImm;
            logic [20:0] expV, gotV;
            eImm = 4'((ext >> (kc * w)) & ((64'd1 << w) - 64'd1));
            expV = {eImm, (mK == n - 1), (mK < n), mRd, mRs1, mRs2};
            gotV = {gImm[d], gLast[d], gBusy[d], gRd[d], gRs1[d], gRs2[d]};
            checks++;
            if (gotV !== expV) begin
                failures++;
                $display("[TB] FAIL %s W=%0d k=%0d: got %0h expected %0h", name, w, mK, gotV, expV);
            end
        end
    endtask

    task automatic modelReset();
        mImm = '0; mFill = 1'b0; mK = BIG;
        mRd = '0; mRs1 = '0; mRs2 = '0;
    endtask

    // Called at a falling edge; returns at the next falling edge after checking.
    task automatic applyStimulus(logic en, logic [31:0] ins, logic [2:0] t, logic cnt);
        wbEn = en; wbRdt = ins[31:2]; immType = t; cntEn = cnt;
        @(posedge clk);
        if (en) begin
            mImm = refImm(ins, t);
            mFill = (t <= 3'd4) ? ins[31] : 1'b0;
            mK = 0;
            mRd = ins[11:7]; mRs1 = ins[19:15]; mRs2 = ins[24:20];
        end else if (cnt) begin
            if (mK < BIG) mK++;
        end
        @(negedge clk);
        wbEn = 1'b0; cntEn = 1'b0;
        checkOutput("cycle");
    endtask

    task automatic resetPulse();
        #1 rst = 1'b1;
        #1;
        for (int d = 0; d < 3; d++)
            checkEq("asyncReset", 32'({gImm[d], gLast[d], gBusy[d], gRd[d], gRs1[d], gRs2[d]}), 32'd0);
        modelReset();
        checkOutput("afterReset");
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("resetRelease");
    endtask

    vector_t vecs[10];
    logic [3:0] iBeats[8];
    logic [31:0] asm[3];

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; wbEn = 1'b0; wbRdt = '0; immType = '0; cntEn = 1'b0;
        modelReset();

        vecs[0] = '{32'h80000013, 3'd0, 32'hFFFFF800, 1'b1, 5'd0,  5'd0,  5'd0};
        vecs[1] = '{32'h123450B7, 3'd3, 32'h12345000, 1'b0, 5'd1,  5'd8,  5'd3};
        vecs[2] = '{32'h00000463, 3'd2, 32'h00000008, 1'b0, 5'd8,  5'd0,  5'd0};
        vecs[3] = '{32'h800FD073, 3'd5, 32'h0000001F, 1'b0, 5'd0,  5'd31, 5'd0};
        vecs[4] = '{32'hFFF00013, 3'd0, 32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  5'd31};
        vecs[5] = '{32'h000010B7, 3'd3, 32'h00001000, 1'b0, 5'd1,  5'd0,  5'd0};
        vecs[6] = '{32'hFE000E23, 3'd1, 32'hFFFFFFFC, 1'b1, 5'd28, 5'd0,  5'd0};
        vecs[7] = '{32'hFFDFF06F, 3'd4, 32'hFFFFFFFC, 1'b1, 5'd0,  5'd31, 5'd29};
        vecs[8] = '{32'hFFFFFFFF, 3'd6, 32'h00000000, 1'b0, 5'd31, 5'd31, 5'd31};
        vecs[9] = '{32'h80000013, 3'd7, 32'h00000000, 1'b0, 5'd0,  5'd0,  5'd0};
        iBeats = '{4'h0, 4'h0, 4'h8, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};

        #12;
        checkOutput("resetState");
        for (int d = 0; d < 3; d++)
            checkEq("resetBusy", 32'(gBusy[d]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 3'd0, 1'b1);
        applyStimulus(1'b0, 32'h0, 3'd0, 1'b1);

        // Table: full 32-bit reassembly per width plus one overrun beat.
        for (int v = 0; v < 10; v++) begin
            applyStimulus(1'b1, vecs[v].instr, vecs[v].immType, 1'b0);
            checkEq("rdAddr",  32'(gRd[0]),  32'(vecs[v].expRd));
            checkEq("rs1Addr", 32'(gRs1[2]), 32'(vecs[v].expRs1));
            checkEq("rs2Addr", 32'(gRs2[1]), 32'(vecs[v].expRs2));
            asm = '{32'd0, 32'd0, 32'd0};
            for (int j = 0; j < 32; j++) begin
                for (int d = 0; d < 3; d++)
                    if (j < (32 >> d))
                        asm[d] = asm[d] | (32'(gImm[d]) << (j * (1 << d)));
                applyStimulus(1'b0, 32'h0, 3'd0, 1'b1);
            end
            applyStimulus(1'b0, 32'h0, 3'd0, 1'b1);
            for (int d = 0; d < 3; d++) begin
                checkEq("assembledImm", asm[d], vecs[v].expImm);
                checkEq("overrunFill", 32'(gImm[d]),
                        vecs[v].expFill ? ((32'd1 << (1 << d)) - 32'd1) : 32'd0);
            end
        end

        // I-type sign on the 4-bit decoder.
        applyStimulus(1'b1, 32'h80000013, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checkEq("iBeatW4", 32'(gImm[2]), 32'(iBeats[i]));
            checkEq("iLastW4", 32'(gLast[2]), 32'(i == 7));
            applyStimulus(1'b0, 32'h0, 3'd0, 1'b1);
        end
        checkEq("iBusyDoneW4", 32'(gBusy[2]), 32'd0);

        // B-type on the 2-bit decoder with an enable gap in the middle.
        applyStimulus(1'b1, 32'h00000463, 3'd2, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checkEq("bBeatW2", 32'(gImm[1]), (i == 1) ? 32'd2 : 32'd0);
            checkEq("bLastW2", 32'(gLast[1]), 32'(i == 15));
            if (i == 1) applyStimulus(1'b0, 32'h0, 3'd0, 1'b0);
            if (i == 1) checkEq("bGapHold", 32'(gImm[1]), 32'd2);
            applyStimulus(1'b0, 32'h0, 3'd0, 1'b1);
        end

        // Load/enable collision aborts the running immediate.
        applyStimulus(1'b1, 32'hFFF00013, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkEq("collBeatW1", 32'(gImm[0]), 32'd1);
            applyStimulus(1'b0, 32'h0, 3'd0, 1'b1);
        end
        applyStimulus(1'b1, 32'h000010B7, 3'd3, 1'b1);
        checkEq("collRestartImm", 32'(gImm[0]), 32'd0);
        checkEq("collRestartBusy", 32'(gBusy[0]), 32'd1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 3'd0, 1'b1);
        checkEq("collBeat12", 32'(gImm[0]), 32'd1);

        // Asynchronous reset in the middle of shifting, then a normal load.
        applyStimulus(1'b1, 32'h123450B7, 3'd3, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 3'd0, 1'b1);
        resetPulse();
        applyStimulus(1'b1, 32'h123450B7, 3'd3, 1'b0);
        checkEq("postResetRd", 32'(gRd[1]), 32'd1);
        checkEq("postResetBusy", 32'(gBusy[1]), 32'd1);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 199) == 0) resetPulse();
            applyStimulus($urandom_range(0, 9) == 0, $urandom, 3'($urandom_range(0, 7)),
                          $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
